decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the mini-rv 5-stage pipeline; sole consumer of the fetch stage's IF/ID outputs and sole driver of fetch's stall input.
- Decodes RV32I instructions, reads the register file, generates immediates, and registers results into the ID/EX pipeline register.
- Detects load-use hazards and stalls fetch.
- Squashes wrong-path instructions when EX reports a taken branch.

Parameters:
- SQUASH_CYCLES, 1: number of fetched instructions dropped after a taken branch (range 1..3).
- RESET_PC, 32'h0000_0000: reset value of id_ex_pc.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- if_id_instr_data  in  32  instruction from fetch
- if_id_pc  in  32  PC of if_id_instr_data
- ex_if_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- id_if_stall  out  1  stall request to fetch (combinational)
- wb_id_we  in  1  writeback enable
- wb_id_rd  in  5  writeback register
- wb_id_data  in  32  writeback data
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_pc  out  32
- id_ex_rs1_data / id_ex_rs2_data  out  32 each
- id_ex_rs1 / id_ex_rs2 / id_ex_rd  out  5 each
- id_ex_imm  out  32  sign-extended immediate
- id_ex_alu_op  out  4  alu_op_e
- id_ex_ctrl  out  ctrl_t  {reg_write, mem_read, mem_write, branch, jump, alu_src_imm, funct3[2:0]}
- id_ex_illegal  out  1  see Optional Feature

Behaviour:
- Reset (async): id_ex_valid=0, id_ex_ctrl=0, id_ex_pc=RESET_PC, all other ID/EX outputs=0, squash counter=0, regfile x1..x31=0.
- Decode latency: combinational decode of if_id_instr_data; results appear on id_ex_* one clock later.
- Immediates follow the RV32I I/S/B/U/J formats, sign-extended to 32 bits. B and J immediates have bit 0 = 0.
- Regfile:
  - x0 reads 0; writes to x0 are ignored.
  - Write-first bypass: if wb_id_we && wb_id_rd==rsN && rsN!=0, read data = wb_id_data in the same cycle.
- Load-use hazard:
  - Raised when id_ex_valid && id_ex_ctrl.mem_read && id_ex_rd!=0 && (id_ex_rd==rs1 || id_ex_rd==rs2).
  - rs1/rs2 count only if the current format uses them: rs2 unused for I/U/J; rs1 unused for U/J.
  - Response: id_if_stall=1 and ID/EX loads a bubble (valid=0, ctrl=0). Fetch holds its outputs, so the same instruction re-decodes next cycle.
  - The stall lasts exactly one cycle.
- Branch flush:
  - When ex_if_branch_taken=1, ID/EX loads a bubble, squash counter := SQUASH_CYCLES, and id_if_stall is forced 0.
  - The counter decrements each cycle; while it is non-zero, ID/EX loads bubbles.
- Priority: rst > ex_if_branch_taken > load-use stall > normal decode.
- A new ex_if_branch_taken while the counter is non-zero reloads it to SQUASH_CYCLES (no underflow; the counter saturates at 0).
- Unknown opcodes decode to a NOP: ctrl=0, valid passes through.
- The first cycle after reset release decodes normally; fetch supplies the RESET_PC instruction.

Optional Feature:
- Macro: ID_ILLEGAL_CHECK_EN.
- Defined:
  - Unknown opcodes, or a bad funct3/funct7 for an OP/OP-IMM shift, set id_ex_illegal=1 with id_ex_valid=1.
  - reg_write, mem_read, mem_write, branch and jump are forced 0.
  - id_ex_illegal is cleared by bubbles.
- Undefined: id_ex_illegal tied 0; the NOP behaviour above applies.

Decomposition:
- Package rv_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), alu_op_e enum (4-bit), ctrl_t packed struct, NOP_INSTR=32'h0000_0013.
- Sub-module regfile: 2 async read ports, 1 sync write port, write-first bypass, async reset.

Test Plan:
- Decode: if_id_instr_data=32'h00500093 (addi x1,x0,5), pc=0x10 -> next cycle id_ex_valid=1, rd=1, imm=5, alu_src_imm=1, reg_write=1, pc=0x10.
- S-immediate: 32'hFE20AE23 (sw x2,-4(x1)) -> id_ex_imm=32'hFFFF_FFFC, mem_write=1, reg_write=0, rs1=1, rs2=2.
- Load-use: 32'h0000A103 (lw x2,0(x1)) then 32'h001101B3 (add x3,x2,x1) -> id_if_stall=1 for exactly one cycle, one bubble, then add issues with valid=1.
- Branch flush with hazard: assert ex_if_branch_taken during a load-use stall, SQUASH_CYCLES=2 -> id_if_stall=0 and valid=0 for 3 cycles (flush cycle + 2 squash cycles), then normal decode.
- WB bypass / x0: wb_id_we=1, rd=5, data=32'hDEADBEEF while decoding add x6,x5,x0 -> rs1_data=DEADBEEF, rs2_data=0; a write to x0 leaves x0 reading 0.
- Async reset mid-stream: pulse rst between clock edges -> id_ex_valid and ctrl go 0 immediately, id_ex_pc=RESET_PC; with ID_ILLEGAL_CHECK_EN, 32'hFFFFFFFF -> illegal=1, reg_write=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions for the mini-rv pipeline: opcodes, ALU ops, control bundle.
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src_imm;
    logic [2:0] funct3;
  } ctrl_t;

  // alt selects SUB/SRA; the caller only raises it where that encoding exists
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, write-first bypass.
module regfile
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs_r [32];

  // Register storage; entry 0 is never written so x0 stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1 with same-cycle writeback bypass
  always_comb begin
    if (raddr1 == 5'd0) begin
      rdata1 = 32'd0;
    end else if (we && (waddr == raddr1)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2 with same-cycle writeback bypass
  always_comb begin
    if (raddr2 == 5'd0) begin
      rdata2 = 32'd0;
    end else if (we && (waddr == raddr2)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage of the mini-rv pipeline: RV32I decode, register read, load-use stall, branch squash.
// Define ID_ILLEGAL_CHECK_EN to flag unsupported encodings on id_ex_illegal.
module decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_instr_data,
  input  logic [31:0] if_id_pc,
  input  logic        ex_if_branch_taken,
  output logic        id_if_stall,
  input  logic        wb_id_we,
  input  logic [4:0]  wb_id_rd,
  input  logic [31:0] wb_id_data,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs1_data,
  output logic [31:0] id_ex_rs2_data,
  output logic [4:0]  id_ex_rs1,
  output logic [4:0]  id_ex_rs2,
  output logic [4:0]  id_ex_rd,
  output logic [31:0] id_ex_imm,
  output alu_op_e     id_ex_alu_op,
  output ctrl_t       id_ex_ctrl,
  output logic        id_ex_illegal
);

  localparam logic [1:0] SQUASH_LOAD = 2'(SQUASH_CYCLES);

  logic [31:0] instr_s;
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] imm_sel_s;
  logic [31:0] rs1_data_s, rs2_data_s;
  alu_op_e     alu_op_s;
  ctrl_t       ctrl_s, ctrl_fin_s;
  logic        use_rs1_s, use_rs2_s;
  logic        illegal_s;
  logic        hazard_s, bubble_s;
  logic [1:0]  squash_cnt_r;

  assign instr_s  = if_id_instr_data;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];
  assign rd_s     = instr_s[11:7];

  assign imm_i_s = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s = {instr_s[31:12], 12'd0};
  assign imm_j_s = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  // Main opcode decode: control bundle, ALU op, immediate format and operand usage
  always_comb begin
    ctrl_s        = '0;
    ctrl_s.funct3 = funct3_s;
    alu_op_s      = ALU_ADD;
    imm_sel_s     = 32'd0;
    use_rs1_s     = 1'b0;
    use_rs2_s     = 1'b0;
    case (opcode_s)
      OP: begin
        ctrl_s.reg_write = 1'b1;
        use_rs1_s        = 1'b1;
        use_rs2_s        = 1'b1;
        alu_op_s         = alu_op_from_funct(funct3_s, instr_s[30]);
      end
      OP_IMM: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        use_rs1_s          = 1'b1;
        imm_sel_s          = imm_i_s;
        alu_op_s           = alu_op_from_funct(funct3_s, instr_s[30] && (funct3_s == 3'b101));
      end
      LOAD: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.mem_read    = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        use_rs1_s          = 1'b1;
        imm_sel_s          = imm_i_s;
      end
      STORE: begin
        ctrl_s.mem_write   = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        use_rs1_s          = 1'b1;
        use_rs2_s          = 1'b1;
        imm_sel_s          = imm_s_s;
      end
      BRANCH: begin
        ctrl_s.branch = 1'b1;
        use_rs1_s     = 1'b1;
        use_rs2_s     = 1'b1;
        imm_sel_s     = imm_b_s;
        alu_op_s      = ALU_SUB;
      end
      JAL: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.jump      = 1'b1;
        imm_sel_s        = imm_j_s;
      end
      JALR: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.jump        = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        use_rs1_s          = 1'b1;
        imm_sel_s          = imm_i_s;
      end
      LUI: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        imm_sel_s          = imm_u_s;
        alu_op_s           = ALU_LUI;
      end
      AUIPC: begin
        ctrl_s.reg_write   = 1'b1;
        ctrl_s.alu_src_imm = 1'b1;
        imm_sel_s          = imm_u_s;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

`ifdef ID_ILLEGAL_CHECK_EN
  // Flag unknown opcodes and shift/funct7 encodings outside RV32I
  always_comb begin
    illegal_s = 1'b0;
    case (opcode_s)
      OP:      illegal_s = ((instr_s[31:25] != 7'b0000000) && (instr_s[31:25] != 7'b0100000)) ||
                           ((instr_s[31:25] == 7'b0100000) && (funct3_s != 3'b000) && (funct3_s != 3'b101));
      OP_IMM:  illegal_s = ((funct3_s == 3'b001) && (instr_s[31:25] != 7'b0000000)) ||
                           ((funct3_s == 3'b101) && (instr_s[31:25] != 7'b0000000) && (instr_s[31:25] != 7'b0100000));
      LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: illegal_s = 1'b0;
      default: illegal_s = 1'b1;
    endcase
  end
`else
  assign illegal_s = 1'b0;
`endif

  // An illegal instruction travels down the pipe but must not have side effects
  always_comb begin
    ctrl_fin_s = ctrl_s;
    if (illegal_s) begin
      ctrl_fin_s.reg_write = 1'b0;
      ctrl_fin_s.mem_read  = 1'b0;
      ctrl_fin_s.mem_write = 1'b0;
      ctrl_fin_s.branch    = 1'b0;
      ctrl_fin_s.jump      = 1'b0;
    end else begin
      ctrl_fin_s = ctrl_s;
    end
  end

  assign hazard_s = id_ex_valid && id_ex_ctrl.mem_read && (id_ex_rd != 5'd0) &&
                    ((use_rs1_s && (id_ex_rd == rs1_s)) || (use_rs2_s && (id_ex_rd == rs2_s)));

  assign id_if_stall = hazard_s && !ex_if_branch_taken;
  assign bubble_s    = ex_if_branch_taken || (squash_cnt_r != 2'd0) || hazard_s;

  regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_id_we),
    .waddr  (wb_id_rd),
    .wdata  (wb_id_data),
    .raddr1 (rs1_s),
    .raddr2 (rs2_s),
    .rdata1 (rs1_data_s),
    .rdata2 (rs2_data_s)
  );

  // Wrong-path squash counter; a new taken branch reloads it, otherwise it drains to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_cnt_r <= 2'd0;
    end else if (ex_if_branch_taken) begin
      squash_cnt_r <= SQUASH_LOAD;
    end else if (squash_cnt_r != 2'd0) begin
      squash_cnt_r <= squash_cnt_r - 2'd1;
    end
  end

  // ID/EX pipeline register; bubbles clear valid, control and the illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= RESET_PC;
      id_ex_rs1_data <= 32'd0;
      id_ex_rs2_data <= 32'd0;
      id_ex_rs1      <= 5'd0;
      id_ex_rs2      <= 5'd0;
      id_ex_rd       <= 5'd0;
      id_ex_imm      <= 32'd0;
      id_ex_alu_op   <= ALU_ADD;
      id_ex_ctrl     <= '0;
      id_ex_illegal  <= 1'b0;
    end else begin
      id_ex_pc       <= if_id_pc;
      id_ex_rs1_data <= rs1_data_s;
      id_ex_rs2_data <= rs2_data_s;
      id_ex_rs1      <= use_rs1_s ? rs1_s : 5'd0;
      id_ex_rs2      <= use_rs2_s ? rs2_s : 5'd0;
      id_ex_rd       <= ctrl_fin_s.reg_write ? rd_s : 5'd0;
      id_ex_imm      <= imm_sel_s;
      id_ex_alu_op   <= alu_op_s;
      if (bubble_s) begin
        id_ex_valid   <= 1'b0;
        id_ex_ctrl    <= '0;
        id_ex_illegal <= 1'b0;
      end else begin
        id_ex_valid   <= 1'b1;
        id_ex_ctrl    <= ctrl_fin_s;
        id_ex_illegal <= illegal_s;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode formats, load-use stall, branch squash, bypass, reset.
module tb_decode_stage;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic        br_taken;
  logic        stall;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        valid;
  logic [31:0] ex_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  alu_op_e     alu_op;
  ctrl_t       ctrl;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.SQUASH_CYCLES(2), .RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .if_id_instr_data   (instr),
    .if_id_pc           (pc),
    .ex_if_branch_taken (br_taken),
    .id_if_stall        (stall),
    .wb_id_we           (wb_we),
    .wb_id_rd           (wb_rd),
    .wb_id_data         (wb_data),
    .id_ex_valid        (valid),
    .id_ex_pc           (ex_pc),
    .id_ex_rs1_data     (rs1_data),
    .id_ex_rs2_data     (rs2_data),
    .id_ex_rs1          (rs1),
    .id_ex_rs2          (rs2),
    .id_ex_rd           (rd),
    .id_ex_imm          (imm),
    .id_ex_alu_op       (alu_op),
    .id_ex_ctrl         (ctrl),
    .id_ex_illegal      (illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = NOP_INSTR; pc = 32'd0; br_taken = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #12;
    check_eq("rst_valid", valid, 32'd0);
    check_eq("rst_pc", ex_pc, RST_PC);
    check_eq("rst_ctrl", ctrl, 32'd0);
    check_eq("rst_imm", imm, 32'd0);
    check_eq("rst_stall", stall, 32'd0);

    // addi x1,x0,5
    rst = 1'b0; instr = 32'h0050_0093; pc = 32'h10;
    step();
    check_eq("addi_valid", valid, 32'd1);
    check_eq("addi_rd", rd, 32'd1);
    check_eq("addi_imm", imm, 32'd5);
    check_eq("addi_srcimm", ctrl.alu_src_imm, 32'd1);
    check_eq("addi_rw", ctrl.reg_write, 32'd1);
    check_eq("addi_pc", ex_pc, 32'h10);
    check_eq("addi_op", alu_op, ALU_ADD);

    // sw x2,-4(x1)
    instr = 32'hFE20_AE23; pc = 32'h14;
    step();
    check_eq("sw_imm", imm, 32'hFFFF_FFFC);
    check_eq("sw_mw", ctrl.mem_write, 32'd1);
    check_eq("sw_rw", ctrl.reg_write, 32'd0);
    check_eq("sw_rs1", rs1, 32'd1);
    check_eq("sw_rs2", rs2, 32'd2);

    // beq x1,x2,+16
    instr = 32'h0020_8863; pc = 32'h18;
    step();
    check_eq("beq_imm", imm, 32'h0000_0010);
    check_eq("beq_br", ctrl.branch, 32'd1);
    check_eq("beq_op", alu_op, ALU_SUB);

    // jal x1,-8
    instr = 32'hFF9F_F0EF; pc = 32'h1C;
    step();
    check_eq("jal_imm", imm, 32'hFFFF_FFF8);
    check_eq("jal_jump", ctrl.jump, 32'd1);
    check_eq("jal_rd", rd, 32'd1);

    // lui x5,0x12345
    instr = 32'h1234_52B7; pc = 32'h20;
    step();
    check_eq("lui_imm", imm, 32'h1234_5000);
    check_eq("lui_op", alu_op, ALU_LUI);

    // lw x2,0(x1) then addi x3,x1,2: rs2 field equals 2 but I-type ignores it
    instr = 32'h0000_A103; pc = 32'h24;
    step();
    check_eq("lw_mr", ctrl.mem_read, 32'd1);
    check_eq("lw_rd", rd, 32'd2);
    instr = 32'h0020_8193; pc = 32'h28;
    #1;
    check_eq("itype_nostall", stall, 32'd0);
    step();

    // lw x2 then add x3,x2,x1: one-cycle load-use stall
    instr = 32'h0000_A103; pc = 32'h2C;
    step();
    instr = 32'h0011_01B3; pc = 32'h30;
    #1;
    check_eq("lu_stall", stall, 32'd1);
    step();
    check_eq("lu_bubble", valid, 32'd0);
    check_eq("lu_stall_end", stall, 32'd0);
    step();
    check_eq("lu_add_valid", valid, 32'd1);
    check_eq("lu_add_rd", rd, 32'd3);
    check_eq("lu_add_rs1", rs1, 32'd2);
    check_eq("lu_add_rs2", rs2, 32'd1);

    // taken branch during a load-use stall, squash of 2
    instr = 32'h0000_A103; pc = 32'h34;
    step();
    instr = 32'h0011_01B3; pc = 32'h38;
    #1;
    check_eq("fl_pre_stall", stall, 32'd1);
    br_taken = 1'b1;
    #1;
    check_eq("fl_stall_forced", stall, 32'd0);
    step();
    br_taken = 1'b0;
    check_eq("fl_v0", valid, 32'd0);
    check_eq("fl_ctrl0", ctrl, 32'd0);
    step();
    check_eq("fl_v1", valid, 32'd0);
    check_eq("fl_s1", stall, 32'd0);
    step();
    check_eq("fl_v2", valid, 32'd0);
    step();
    check_eq("fl_resume", valid, 32'd1);
    check_eq("fl_resume_rd", rd, 32'd3);

    // add x6,x5,x0 with writeback bypass of x5, then x0 write ignored
    instr = 32'h0002_8333; pc = 32'h40;
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    check_eq("byp_rs1", rs1_data, 32'hDEAD_BEEF);
    check_eq("byp_rs2", rs2_data, 32'd0);
    wb_we = 1'b0;
    step();
    check_eq("rf_rs1", rs1_data, 32'hDEAD_BEEF);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678;
    step();
    check_eq("x0_byp", rs2_data, 32'd0);
    wb_we = 1'b0;
    step();
    check_eq("x0_rf", rs2_data, 32'd0);

    // unknown opcode
    instr = 32'hFFFF_FFFF; pc = 32'h50;
    step();
    check_eq("unk_valid", valid, 32'd1);
    check_eq("unk_ctrl", ctrl, 32'd0);
`ifdef ID_ILLEGAL_CHECK_EN
    check_eq("unk_illegal", illegal, 32'd1);
`else
    check_eq("unk_illegal", illegal, 32'd0);
`endif

    // asynchronous reset between edges
    instr = 32'h0050_0093; pc = 32'h60;
    step();
    check_eq("ar_pre_valid", valid, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", valid, 32'd0);
    check_eq("ar_ctrl", ctrl, 32'd0);
    check_eq("ar_pc", ex_pc, RST_PC);
    #1;
    rst = 1'b0;
    step();
    check_eq("ar_post_valid", valid, 32'd1);
    check_eq("ar_post_pc", ex_pc, 32'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
